crc_match_collector: RTL and testbench
======================================

Name: crc_match_collector

Overview:
- Downstream consumer of the pipelined CRC chain's `outp_data`.
- Launch side: the stage feeding the CRC chain also drives `in_valid` and a candidate tag into this block in the same cycle it presents `inp_data`.
- Alignment: the block delays `in_valid`/tag by the chain latency so each hash is paired with the candidate that produced it.
- Per aligned hash:
  - compares it to a target hash;
  - counts matches;
  - buffers matching `{tag, hash}` pairs in a small FIFO read out over valid/ready.
- A run-control FSM (start/stop/drain/done) brackets a search run.

Parameters:
- p_len, 128, CRC chain latency in cycles (delay-line depth); ≥1
- p_width, 8, hash width
- p_tag_width, 8, candidate tag width
- p_fifo_depth, 4, match FIFO entries; power of two ≥2
- p_cnt_width, 16, match counter width

Ports:
- clk  in  1  clock
- rstN  in  1  reset; synchronous, active-high despite the N suffix
- start  in  1  pulse; begin a run
- stop  in  1  pulse; end launching, then drain
- target_hash  in  p_width  value to match; sampled every cycle
- in_valid  in  1  candidate launched into CRC chain this cycle
- in_tag  in  p_tag_width  candidate identifier
- hash_in  in  p_width  CRC chain output (`outp_data`)
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_tag  out  p_tag_width  head tag
- m_hash  out  p_width  head hash
- match_count  out  p_cnt_width  matches this run, saturating
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- overflow  out  1  sticky: a match was dropped because the FIFO was full

Behaviour:
- Reset (rstN=1 at a clk edge):
  - state=IDLE;
  - delay-line valids cleared;
  - FIFO emptied;
  - `match_count`=0, `overflow`=0;
  - `m_valid`=0, `busy`=0, `done`=0.
  - Reset mid-run discards all in-flight and buffered data.
- Delay line:
  - p_len-stage shift register of {v, tag}.
  - Stage-0 input v = `in_valid` AND (state==RUN); tag = `in_tag`.
  - Output `{dv, dtag}` at cycle t corresponds to the launch at t−p_len, aligned with `hash_in` at t.
  - `in_valid` outside RUN is ignored (v=0 launched).
- Match: `hit` = dv AND (`hash_in`==`target_hash`).
- Match counter: on `hit`, `match_count` increments, saturating at all-ones.
- FIFO push and drop:
  - On `hit` the FIFO pushes `{dtag, hash_in}`.
  - If full and not popping this cycle, the entry is dropped and `overflow` is set.
  - `match_count` still increments on a dropped entry.
- FIFO pop: pop = `m_valid` AND `m_ready`.
- Simultaneous push and pop:
  - when full: both take effect, count unchanged, no drop;
  - when empty: the push is written, and `m_valid` rises the next cycle (no fall-through).
- FIFO outputs: `m_tag`/`m_hash` are registered head contents, stable while `m_valid`=1 and `m_ready`=0.
- Read/write pointers: log2(p_fifo_depth)+1 bits; wrap naturally; full/empty from MSB comparison.
- FSM transitions:
  - IDLE: `start` → RUN. On entry to RUN, `match_count` and `overflow` are cleared; FIFO contents are retained.
  - RUN: `stop` → DRAIN; drain counter loaded with p_len. `start` is ignored.
  - DRAIN: counter decrements each cycle; at 0 → DONE. Hits from in-flight launches are still processed. `start`/`stop` are ignored.
  - DONE: `start` → RUN (same clears as from IDLE). `stop` is ignored.
- Start and stop together:
  - in IDLE/DONE: start wins.
  - in RUN: stop wins.
- `busy`/`done` are decoded from registered state.

Decomposition:
- Package `crc_collector_pkg`: state enum (IDLE, RUN, DRAIN, DONE); function clog2 for pointer width.
- Sub-module `match_fifo`: parameterized sync FIFO (width p_tag_width+p_width, depth p_fifo_depth) with push/pop/full/empty.
- Delay line, comparator, counter and FSM stay in the top.

Test Plan (p_len=4, p_width=8, p_fifo_depth=4, target_hash=8'h5A unless stated):
- Reset → all outputs 0.
  - Assert rstN mid-RUN with 2 FIFO entries → next cycle `m_valid`=0, `match_count`=0, state IDLE.
- Alignment: start, launch tag 8'h11 at cycle t, drive `hash_in`=8'h5A only at t+4 → one entry {8'h11, 8'h5A}, `m_valid`=1 at t+5, `match_count`=1.
  - `hash_in`=8'h5A at t+3 or t+5 → no entry.
- Overflow: 6 consecutive hits with `m_ready`=0 → FIFO holds the first 4 tags, `overflow`=1, `match_count`=6.
  - Drain with `m_ready`=1 → tags in launch order.
- Full + simultaneous pop: FIFO full, `m_ready`=1, hit same cycle → no drop, `overflow` stays 0, count of entries stays 4.
- FSM drain: `stop` asserted 1 cycle after the last launch → `busy`=1 for exactly 4 more cycles and that launch's hit is captured; `done`=1 after.
  - `in_valid` during DRAIN → never produces an entry.
- Restart: `start` in DONE → `match_count`=0, `overflow`=0, previous FIFO entries still readable.
  - Counter saturation (p_cnt_width=2): 5 hits → `match_count`=3.

Source files
------------

// File: rtl/crc_collector_pkg.sv
// Shared types and helpers for the CRC match collector: run-control states
// and a constant ceil-log2 used to size pointers and counters.
package crc_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    for (int v = n - 32'sd1; v > 32'sd0; v = v >> 1) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/match_fifo.sv
// Small synchronous FIFO holding matched {tag, hash} pairs; no fall-through,
// head is read straight from storage so it is stable while not popped.
module match_fifo
  import crc_collector_pkg::*;
#(
  parameter int p_data_width = 16,
  parameter int p_depth      = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    push,
  input  logic                    pop,
  input  logic [p_data_width-1:0] din,
  output logic [p_data_width-1:0] dout,
  output logic                    full,
  output logic                    empty
);

  localparam int idx_w = clog2(p_depth);
  localparam int ptr_w = idx_w + 1;

  logic [p_data_width-1:0] mem [p_depth];
  logic [ptr_w-1:0]        wr_ptr;
  logic [ptr_w-1:0]        rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ptr_w-1] != rd_ptr[ptr_w-1]) &&
                   (wr_ptr[idx_w-1:0] == rd_ptr[idx_w-1:0]);
  assign do_pop  = pop && !empty;
  // a pop frees the slot this cycle, so a push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[idx_w-1:0]];

  always_ff @(posedge clk) begin
    if (rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_w'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[idx_w-1:0]] <= din;
  end

endmodule

// File: rtl/crc_match_collector.sv
// Pairs each CRC chain output with the candidate that produced it, counts
// target matches and buffers matching {tag, hash} pairs for a consumer.
module crc_match_collector
  import crc_collector_pkg::*;
#(
  parameter int p_len        = 128,
  parameter int p_width      = 8,
  parameter int p_tag_width  = 8,
  parameter int p_fifo_depth = 4,
  parameter int p_cnt_width  = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   start,
  input  logic                   stop,
  input  logic [p_width-1:0]     target_hash,
  input  logic                   in_valid,
  input  logic [p_tag_width-1:0] in_tag,
  input  logic [p_width-1:0]     hash_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [p_tag_width-1:0] m_tag,
  output logic [p_width-1:0]     m_hash,
  output logic [p_cnt_width-1:0] match_count,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int data_w  = p_tag_width + p_width;
  localparam int drain_w = clog2(p_len + 1);

  state_t                 state;
  state_t                 next_state;
  logic                   run_entry;
  logic [drain_w-1:0]     drain_cnt;
  logic [p_len-1:0]       line_v;
  logic [p_tag_width-1:0] line_tag [p_len];
  logic                   launch;
  logic                   dv;
  logic [p_tag_width-1:0] dtag;
  logic                   hit;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [data_w-1:0]      head;

  assign launch  = in_valid && (state == RUN);
  assign dv      = line_v[p_len-1];
  assign dtag    = line_tag[p_len-1];
  assign hit     = dv && (hash_in == target_hash);
  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign drop    = hit && fifo_full && !pop;
  assign m_tag   = head[data_w-1:p_width];
  assign m_hash  = head[p_width-1:0];
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);

  always_comb begin
    next_state = state;
    run_entry  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = RUN;
          run_entry  = 1'b1;
        end else begin
          next_state = state;
        end
      end
      RUN: begin
        if (stop) next_state = DRAIN;
        else      next_state = RUN;
      end
      // DRAIN lasts exactly p_len cycles so the final launch still lands
      DRAIN: begin
        if (drain_cnt <= drain_w'(1)) next_state = DONE;
        else                          next_state = DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      if ((state == RUN) && stop) drain_cnt <= drain_w'(p_len);
      else if (state == DRAIN)    drain_cnt <= drain_cnt - drain_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      line_v <= '0;
    end else begin
      line_v[0] <= launch;
      for (int i = 1; i < p_len; i++) line_v[i] <= line_v[i-1];
    end
  end

  always_ff @(posedge clk) begin
    line_tag[0] <= in_tag;
    for (int i = 1; i < p_len; i++) line_tag[i] <= line_tag[i-1];
  end

  // a dropped entry still counts as a match
  always_ff @(posedge clk) begin
    if (rstN || run_entry) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (hit && (match_count != {p_cnt_width{1'b1}}))
        match_count <= match_count + p_cnt_width'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  match_fifo #(
    .p_data_width (data_w),
    .p_depth      (p_fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (hit),
    .pop   (pop),
    .din   ({dtag, hash_in}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_crc_match_collector.sv
// Directed bench for crc_match_collector (p_len=4, depth 4, target 8'h5A),
// with a second instance using a 2-bit counter to observe saturation.
module tb_crc_match_collector;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] target_hash;
  logic       in_valid;
  logic [7:0] in_tag;
  logic [7:0] hash_in;
  logic       m_ready;

  logic        m_valid;
  logic [7:0]  m_tag;
  logic [7:0]  m_hash;
  logic [15:0] match_count;
  logic        busy;
  logic        done;
  logic        overflow;

  logic       s_m_valid;
  logic [7:0] s_m_tag;
  logic [7:0] s_m_hash;
  logic [1:0] s_match_count;
  logic       s_busy;
  logic       s_done;
  logic       s_overflow;

  int checks;
  int failures;

  crc_match_collector #(
    .p_len(4), .p_width(8), .p_tag_width(8), .p_fifo_depth(4), .p_cnt_width(16)
  ) dut (
    .clk(clk), .rstN(rst), .start(start), .stop(stop), .target_hash(target_hash),
    .in_valid(in_valid), .in_tag(in_tag), .hash_in(hash_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_tag(m_tag), .m_hash(m_hash),
    .match_count(match_count), .busy(busy), .done(done), .overflow(overflow)
  );

  crc_match_collector #(
    .p_len(4), .p_width(8), .p_tag_width(8), .p_fifo_depth(4), .p_cnt_width(2)
  ) dut_sat (
    .clk(clk), .rstN(rst), .start(start), .stop(stop), .target_hash(target_hash),
    .in_valid(in_valid), .in_tag(in_tag), .hash_in(hash_in),
    .m_valid(s_m_valid), .m_ready(m_ready), .m_tag(s_m_tag), .m_hash(s_m_hash),
    .match_count(s_match_count), .busy(s_busy), .done(s_done), .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        in_valid;
    logic [7:0]  tag;
    logic [7:0]  hash;
    logic        m_ready;
    logic        e_mv;
    logic [7:0]  e_tag;
    logic [15:0] e_cnt;
    logic        e_busy;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic st, input logic sp, input logic iv,
                         input logic [7:0] tg, input logic [7:0] hs, input logic rdy,
                         input logic e_mv, input logic [7:0] e_tag, input logic [15:0] e_cnt,
                         input logic e_busy, input logic e_done, input logic e_ovf);
    vec_t v;
    v.start = st; v.stop = sp; v.in_valid = iv; v.tag = tg; v.hash = hs; v.m_ready = rdy;
    v.e_mv = e_mv; v.e_tag = e_tag; v.e_cnt = e_cnt;
    v.e_busy = e_busy; v.e_done = e_done; v.e_ovf = e_ovf;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_tag = 8'h00;
    hash_in = 8'h00; m_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    target_hash = 8'h5A;
    set_idle();
    rst = 1'b1;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("reset m_valid", 32'(m_valid), 32'd0);
    chk("reset match_count", 32'(match_count), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset sat count", 32'(s_match_count), 32'd0);

    // alignment (launch 8'h11, hash 5A at t+3, t+4, t+5), pop, stop and drain
    //       st    sp    iv    tag    hash   rdy   e_mv  e_tag  e_cnt  busy  done  ovf
    add_vec(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h11, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1, 8'h11, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd1, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'd1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; stop = vq[i].stop; in_valid = vq[i].in_valid;
      in_tag = vq[i].tag; hash_in = vq[i].hash; m_ready = vq[i].m_ready;
      tick();
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vq[i].e_mv));
      chk($sformatf("vec%0d match_count", i), 32'(match_count), 32'(vq[i].e_cnt));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vq[i].e_done));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vq[i].e_ovf));
      if (vq[i].e_mv) begin
        chk($sformatf("vec%0d m_tag", i), 32'(m_tag), 32'(vq[i].e_tag));
        chk($sformatf("vec%0d m_hash", i), 32'(m_hash), 32'h5A);
      end
    end
    set_idle();
    chk("table sat count", 32'(s_match_count), 32'd1);

    // restart from DONE, then six hits with no consumer
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart count clear", 32'(match_count), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    hash_in = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_tag = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("ovf match_count", 32'(match_count), 32'd6);
    chk("ovf overflow", 32'(overflow), 32'd1);
    chk("ovf sat count", 32'(s_match_count), 32'd3);
    chk("ovf m_hash", 32'(m_hash), 32'h5A);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf pop%0d m_valid", k), 32'(m_valid), 32'd1);
      chk($sformatf("ovf pop%0d m_tag", k), 32'(m_tag), 32'(k + 1));
      tick();
    end
    m_ready = 1'b0;
    chk("ovf drained m_valid", 32'(m_valid), 32'd0);

    // last launch, stop one cycle later, in_valid held through DRAIN/DONE
    in_valid = 1'b1;
    in_tag = 8'h77;
    tick();
    in_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    in_valid = 1'b1;
    in_tag = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain cycle%0d busy", k), 32'(busy), 32'd1);
      chk($sformatf("drain cycle%0d done", k), 32'(done), 32'd0);
      tick();
    end
    chk("drain end busy", 32'(busy), 32'd0);
    chk("drain end done", 32'(done), 32'd1);
    repeat (5) tick();
    in_valid = 1'b0;
    chk("drain match_count", 32'(match_count), 32'd7);
    chk("drain m_valid", 32'(m_valid), 32'd1);
    chk("drain m_tag", 32'(m_tag), 32'h77);

    // restart keeps FIFO contents, clears count and overflow
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart2 count", 32'(match_count), 32'd0);
    chk("restart2 overflow", 32'(overflow), 32'd0);
    chk("restart2 sat count", 32'(s_match_count), 32'd0);
    chk("restart2 m_valid", 32'(m_valid), 32'd1);
    chk("restart2 m_tag", 32'(m_tag), 32'h77);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("restart2 single entry", 32'(m_valid), 32'd0);

    // full FIFO with pop and hit in the same cycle; start in RUN ignored
    for (int c = 0; c <= 8; c++) begin
      in_valid = (c <= 4);
      in_tag = 8'(8'hA1 + c);
      m_ready = (c == 8);
      start = (c == 6);
      if (c == 8) begin
        chk("full head valid", 32'(m_valid), 32'd1);
        chk("full head tag", 32'(m_tag), 32'hA1);
      end
      tick();
    end
    set_idle();
    hash_in = 8'h5A;
    tick();
    chk("fullpop overflow", 32'(overflow), 32'd0);
    chk("fullpop match_count", 32'(match_count), 32'd5);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fullpop pop%0d m_valid", k), 32'(m_valid), 32'd1);
      chk($sformatf("fullpop pop%0d m_tag", k), 32'(m_tag), 32'(8'hA2 + k));
      tick();
    end
    m_ready = 1'b0;
    chk("fullpop drained", 32'(m_valid), 32'd0);

    // reset mid-run with two buffered entries and one launch in flight
    in_valid = 1'b1;
    in_tag = 8'hB1;
    tick();
    in_tag = 8'hB2;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("prereset m_valid", 32'(m_valid), 32'd1);
    chk("prereset match_count", 32'(match_count), 32'd7);
    in_valid = 1'b1;
    in_tag = 8'hB3;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset m_valid", 32'(m_valid), 32'd0);
    chk("midreset match_count", 32'(match_count), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    repeat (6) tick();
    chk("midreset inflight m_valid", 32'(m_valid), 32'd0);
    chk("midreset inflight count", 32'(match_count), 32'd0);

    // start+stop together: start wins in IDLE, stop wins in RUN
    start = 1'b1;
    stop = 1'b1;
    tick();
    chk("startstop idle busy", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop run busy", 32'(busy), 32'd1);
    repeat (4) tick();
    chk("startstop run done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
